cpu_program_sequencer: RTL and testbench
========================================

// Module: cpu_program_sequencer
// PURPOSE
//  Feeds a fixed instruction program to the lab6 cpu with no switches or keys. It replaces the
//  manual load/s button presses with a hardware loop. Loop: fetch a word from an instruction ROM,
//  pulse cpu load, pulse cpu s, wait for the cpu's w handshake, then capture cpu out.
//  Sits between a ROM and the cpu instance. result drives the sseg displays.
// PARAMETERS
//  N_INSTR   8     number of ROM words in the program (1..2**ADDR_W)
//  ADDR_W    3     ROM address width
//  TIMEOUT   255   max cycles allowed in any wait state before the error state ERR
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   synchronous, active-high
//  go            in   1   start the program from address 0 (level; sampled in IDLE, DONE, ERR)
//  abort         in   1   return to IDLE on the next edge
//  rom_addr      out  ADDR_W  ROM read address (combinational ROM, data valid in same cycle)
//  rom_data      in   16  ROM word at rom_addr
//  cpu_in        out  16  instruction to cpu (held = instr register)
//  cpu_load      out  1   cpu load strobe
//  cpu_s         out  1   cpu start strobe
//  cpu_w         in   1   cpu waiting (1 = idle in wait state)
//  cpu_out       in   16  cpu register C output
//  result        out  16  last captured cpu_out
//  result_valid  out  1   1-cycle pulse when result updates
//  busy          out  1   1 in every state except IDLE/DONE/ERR
//  done          out  1   1 while in DONE
//  err           out  1   1 while in ERR
//  pc            out  ADDR_W  index of the current instruction
// BEHAVIOUR
//  Reset:
//   - state=IDLE.
//   - All outputs 0: pc, rom_addr, cpu_in, result, all strobes and flags.
//   - Reset overrides go and abort, and applies mid-operation.
//  States and transitions:
//   - IDLE: go=1 -> READY, with pc<=0.
//   - READY: wait for cpu_w=1.
//     - If cpu_w is already 1 on entry, leave after 1 cycle.
//     - cpu_w=1 -> FETCH.
//   - FETCH: rom_addr=pc; instr<=rom_data.
//     - rom_data==16'hFFFF (END marker) -> DONE, no load issued.
//     - Otherwise -> LOAD.
//   - LOAD: cpu_load=1 for exactly 1 cycle -> START.
//   - START: cpu_s=1 for exactly 1 cycle -> LEAVE.
//   - LEAVE: wait for cpu_w=0, i.e. the cpu accepted s -> RUN.
//   - RUN: wait for cpu_w=1 -> CAPT.
//   - CAPT: result<=cpu_out; result_valid=1 for 1 cycle.
//     - pc==N_INSTR-1 -> DONE.
//     - Otherwise pc<=pc+1 -> READY.
//   - DONE and ERR: hold state and all outputs.
//     - go=1 restarts: pc<=0 -> READY; result is kept until the next CAPT.
//  cpu_in: equals the instr register from LOAD through CAPT, and is stable across the load edge.
//  Strobes: cpu_load and cpu_s are registered (Moore outputs), never both 1, and never 1 outside
//   LOAD/START.
//  Watchdog:
//   - Counter cleared on entry to READY, LEAVE or RUN; increments each cycle spent there.
//   - Reaching TIMEOUT -> ERR; pc is frozen at the failing instruction.
//  Abort:
//   - From any state -> IDLE next edge; strobes drop immediately.
//   - pc, result and result_valid are cleared; err is cleared.
//   - abort and go in the same cycle: abort wins.
//  Widths: pc does not wrap past N_INSTR-1; an END marker terminates early. Per instruction the
//   minimum is 6 cycles (READY, FETCH, LOAD, START, LEAVE, RUN) + CAPT = 7 cycles.
// STRUCTURE
//  Package seq_pkg:
//   - State encoding localparams: IDLE, READY, FETCH, LOAD, START, LEAVE, RUN, CAPT, DONE, ERR
//     (4-bit).
//   - END_MARKER = 16'hFFFF.
//  Sub-module seq_watchdog:
//   - Ports: clk, reset, clear, en -> expired; width $clog2(TIMEOUT+1).
//   - Everything else is a single FSM plus datapath registers in this module.
// TESTING
//  Bench cpu model: w drops 1 cycle after s, stays low 3 cycles, out = 16'h0007 + pc.
//  1. ROM = {D007, D102, A0A1, ...}, N_INSTR=3, pulse go -> result_valid 3 times with
//     0007, 0008, 0009; then done=1, pc=2.
//  2. ROM[1]=FFFF -> exactly 1 result_valid (0007); DONE with pc=1; cpu_load pulsed once total.
//  3. Model never lowers w after s, TIMEOUT=255 -> err=1 at 255 cycles after LEAVE entry;
//     pc=0; cpu_s stays 0.
//  4. Assert abort during RUN of instr 1 -> next cycle IDLE; busy=0, pc=0, result=0; no further
//     strobes.
//  5. Assert reset in START -> next cycle every output 0. A go pulse afterwards reruns
//     scenario 1 identically.
//  6. go held during busy and go+abort together -> go ignored while busy; abort wins (IDLE).
//     go in DONE restarts with pc=0 and result kept until the first CAPT.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and constants shared by the program sequencer
package seq_pkg;
  typedef enum logic [3:0] {
    IDLE, READY, FETCH, LOAD, START, LEAVE, RUN, CAPT, DONE, ERR
  } state_t;
  localparam logic [15:0] END_MARKER = 16'hFFFF;
endpackage

// File: rtl/cpu_program_sequencer_if.sv
// cpu_program_sequencer_if: control, ROM and cpu signals between the sequencer and its environment
interface cpu_program_sequencer_if #(parameter int ADDR_W = 3);
  logic go, abort;
  logic [ADDR_W-1:0] rom_addr, pc;
  logic [15:0] rom_data, cpu_in, cpu_out, result;
  logic cpu_load, cpu_s, cpu_w, result_valid, busy, done, err;
  modport master (
    input  go, abort, rom_data, cpu_w, cpu_out,
    output rom_addr, cpu_in, cpu_load, cpu_s, result, result_valid, busy, done, err, pc
  );
  modport slave (
    output go, abort, rom_data, cpu_w, cpu_out,
    input  rom_addr, cpu_in, cpu_load, cpu_s, result, result_valid, busy, done, err, pc
  );
endinterface

// File: rtl/seq_watchdog.sv
// seq_watchdog: counts cycles spent in a wait state and flags when TIMEOUT is reached
module seq_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || clear) ? '0 : en ? cnt + 1'b1 : cnt;
  assign expired = en && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/cpu_program_sequencer.sv
// cpu_program_sequencer: steps a ROM program through the cpu via load/s strobes and w handshake
module cpu_program_sequencer
  import seq_pkg::*;
#(
  parameter int N_INSTR = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  cpu_program_sequencer_if.master bus
);
  state_t state, next;
  logic [ADDR_W-1:0] pc;
  logic [15:0] instr, result;
  logic result_valid, expired, last, idle_like;
  assign last = pc == ADDR_W'(N_INSTR - 1);
  assign idle_like = state inside {IDLE, DONE, ERR};
  // any state change restarts the count, so each wait state gets a fresh budget
  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .reset(reset),
    .clear(next != state),
    .en(state inside {READY, LEAVE, RUN}),
    .expired(expired)
  );
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = bus.go ? READY : IDLE;
      READY:     next = bus.cpu_w ? FETCH : expired ? ERR : READY;
      FETCH:     next = bus.rom_data == END_MARKER ? DONE : LOAD;
      LOAD:      next = START;
      START:     next = LEAVE;
      LEAVE:     next = !bus.cpu_w ? RUN : expired ? ERR : LEAVE;
      RUN:       next = bus.cpu_w ? CAPT : expired ? ERR : RUN;
      CAPT:      next = last ? DONE : READY;
      DONE, ERR: next = bus.go ? READY : state;
      default:   next = IDLE;
    endcase
    if (bus.abort) next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      instr <= '0;
      result <= '0;
      result_valid <= 1'b0;
    end else if (bus.abort) begin
      pc <= '0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= state == CAPT;
      if (state == FETCH && bus.rom_data != END_MARKER) instr <= bus.rom_data;
      if (state == CAPT) result <= bus.cpu_out;
      if (state == CAPT && !last) pc <= pc + 1'b1;
      if (idle_like && bus.go) pc <= '0;
    end
  end
  assign bus.rom_addr = pc;
  assign bus.pc = pc;
  assign bus.cpu_in = instr;
  assign bus.cpu_load = state == LOAD;
  assign bus.cpu_s = state == START;
  assign bus.result = result;
  assign bus.result_valid = result_valid;
  assign bus.busy = !idle_like;
  assign bus.done = state == DONE;
  assign bus.err = state == ERR;
endmodule

// File: tb/tb_cpu_program_sequencer.sv
// tb_cpu_program_sequencer: random programs against a cpu model, scoreboard of loads and results
module tb_cpu_program_sequencer;
  localparam int N = 3, AW = 3, TO = 255;
  logic clk = 1'b0, reset = 1'b1;
  cpu_program_sequencer_if #(.ADDR_W(AW)) bus ();
  cpu_program_sequencer #(.N_INSTR(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [15:0] rom [8];
  logic [15:0] exp_res [$];
  logic [15:0] exp_ins [$];
  logic [15:0] prev_res = 16'h0, last_ins = 16'h0;
  int s_cnt = 0, s_base = 0, low_len = 3, low = 0, load_cnt = 0, cyc = 0;
  int n_checks = 0, n_fail = 0;
  bit hang = 1'b0;
  assign bus.rom_data = rom[bus.rom_addr];
  assign bus.cpu_out = 16'h0007 + 16'(s_cnt - s_base - 1);
  always @(posedge clk) cyc <= cyc + 1;
  // cpu model: w falls the cycle after s, stays low low_len cycles; hang keeps it high
  always @(posedge clk) begin
    if (bus.cpu_s) s_cnt <= s_cnt + 1;
    if (reset) begin
      bus.cpu_w <= 1'b1;
      low <= 0;
    end else if (bus.cpu_s && !hang) begin
      bus.cpu_w <= 1'b0;
      low <= low_len;
    end else if (low > 0) begin
      low <= low - 1;
      if (low == 1) bus.cpu_w <= 1'b1;
    end
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (bus.result_valid) begin
      check("result_expected", 64'(exp_res.size() != 0), 64'd1);
      if (exp_res.size() != 0) check("result", 64'(bus.result), 64'(exp_res.pop_front()));
    end
    if (bus.cpu_load) begin
      load_cnt++;
      check("load_expected", 64'(exp_ins.size() != 0), 64'd1);
      if (exp_ins.size() != 0) last_ins = exp_ins.pop_front();
      check("cpu_in_load", 64'(bus.cpu_in), 64'(last_ins));
    end
    if (bus.cpu_s) check("cpu_in_start", 64'(bus.cpu_in), 64'(last_ins));
    if (bus.cpu_load || bus.cpu_s)
      check("strobe_excl_busy", 64'({bus.cpu_load & bus.cpu_s, bus.busy}), 64'd1);
  end
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("reset_zero", 64'({bus.pc, bus.rom_addr, bus.cpu_in, bus.result, bus.cpu_load, bus.cpu_s,
                            bus.result_valid, bus.busy, bus.done, bus.err}), 64'd0);
    reset = 1'b0;
    exp_res.delete();
    exp_ins.delete();
    prev_res = 16'h0;
  endtask
  task automatic start(input int hold);
    @(negedge clk);
    s_base = s_cnt;
    bus.go = 1'b1;
    @(negedge clk);
    check("restart_pc", 64'(bus.pc), 64'd0);
    check("restart_busy", 64'(bus.busy), 64'd1);
    check("result_kept", 64'(bus.result), 64'(prev_res));
    repeat (hold - 1) @(negedge clk);
    bus.go = 1'b0;
  endtask
  task automatic wait_end();
    int i = 0;
    while (!(bus.done || bus.err) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    check("end_reached", 64'(bus.done || bus.err), 64'd1);
    @(negedge clk);
  endtask
  task automatic wait_s();
    int i = 0;
    while (!bus.cpu_s && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("start_seen", 64'(bus.cpu_s), 64'd1);
  endtask
  // reference: run from word 0 until END marker or the last word, one result 7+k per instruction
  task automatic run_prog(input int hold);
    int end_pc = N - 1;
    logic [15:0] last_res = prev_res;
    for (int k = 0; k < N; k++) begin
      if (rom[k] == 16'hFFFF) begin
        end_pc = k;
        break;
      end
      exp_ins.push_back(rom[k]);
      last_res = 16'h0007 + 16'(k);
      exp_res.push_back(last_res);
    end
    start(hold);
    wait_end();
    check("done", 64'(bus.done), 64'd1);
    check("err", 64'(bus.err), 64'd0);
    check("end_pc", 64'(bus.pc), 64'(end_pc));
    check("pending", 64'(exp_res.size() + exp_ins.size()), 64'd0);
    prev_res = last_res;
  endtask
  task automatic load_s1();
    rom[0] = 16'hD007; rom[1] = 16'hD102; rom[2] = 16'hA0A1;
    for (int k = 3; k < 8; k++) rom[k] = 16'h1111 * 16'(k);
  endtask
  initial begin
    int ld, t0, i;
    bus.go = 1'b0;
    bus.abort = 1'b0;
    load_s1();
    do_reset();
    run_prog(1);
    rom[1] = 16'hFFFF;
    ld = load_cnt;
    run_prog(1);
    check("single_load", 64'(load_cnt - ld), 64'd1);
    load_s1();
    hang = 1'b1;
    exp_ins.push_back(rom[0]);
    start(1);
    wait_s();
    t0 = cyc;
    i = 0;
    while (!bus.err && i < 400) begin
      @(negedge clk);
      i++;
    end
    check("wd_latency", 64'(cyc - t0), 64'd256);
    check("err_state", 64'({bus.err, bus.done, bus.busy}), 64'd4);
    check("err_pc", 64'(bus.pc), 64'd0);
    check("err_no_more_s", 64'(s_cnt - s_base), 64'd1);
    check("err_pending", 64'(exp_ins.size()), 64'd0);
    hang = 1'b0;
    run_prog(1);
    exp_ins.push_back(rom[0]);
    exp_ins.push_back(rom[1]);
    exp_res.push_back(16'h0007);
    start(1);
    i = 0;
    while (s_cnt != s_base + 2 && i < 100) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_state", 64'({bus.busy, bus.done, bus.err, bus.result_valid}), 64'd0);
    check("abort_pc", 64'(bus.pc), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    ld = load_cnt;
    repeat (15) @(negedge clk);
    check("abort_no_strobe", 64'({load_cnt - ld, s_cnt - s_base}), 64'({32'd0, 32'd2}));
    check("abort_pending", 64'(exp_ins.size() + exp_res.size()), 64'd0);
    prev_res = 16'h0;
    exp_ins.push_back(rom[0]);
    start(1);
    wait_s();
    do_reset();
    run_prog(1);
    bus.go = 1'b1;
    bus.abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("go_abort_done", 64'({bus.busy, bus.done}), 64'd0);
    end
    bus.abort = 1'b0;
    @(negedge clk);
    bus.abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("go_abort_busy", 64'({bus.busy, bus.pc}), 64'd0);
    end
    bus.go = 1'b0;
    bus.abort = 1'b0;
    prev_res = 16'h0;
    run_prog(8);
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 8; k++) begin
        rom[k] = 16'($urandom);
        if (rom[k] == 16'hFFFF) rom[k] = 16'h0;
      end
      if ($urandom_range(2, 0) == 0) rom[$urandom_range(N - 1, 0)] = 16'hFFFF;
      low_len = int'($urandom_range(4, 1));
      run_prog(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
